// File: rtl/alu_mp_sequencer_pkg.sv
// Shared definitions for the multi-precision ALU sequencer: ALU opcodes,
// FSM state encoding and the arithmetic-op classifier.
package alu_mp_sequencer_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_BMA  = 3'b010;
  localparam logic [2:0] OP_BIC  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_XNOR = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    P1   = 2'd1,
    P2   = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_BMA);
  endfunction

endpackage

// File: rtl/alu_mp_sequencer_if.sv
// Command and result handshakes of the multi-precision sequencer.
interface alu_mp_sequencer_if #(
  parameter int W  = 4,
  parameter int NW = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [NW*W-1:0]   cmd_a;
  logic [NW*W-1:0]   cmd_b;
  logic              res_valid;
  logic              res_ready;
  logic [NW*W-1:0]   res_y;
  logic              res_n;
  logic              res_z;
  logic              res_c;
  logic              res_v;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
    input  cmd_ready, res_valid, res_y, res_n, res_z, res_c, res_v
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
    output cmd_ready, res_valid, res_y, res_n, res_z, res_c, res_v
  );
endinterface

// File: rtl/alu_mp_sequencer.sv
// Runs NW*W-bit operations on an external W-bit ALU one word at a time,
// LSW first; arithmetic words take a second pass to fold in carry/borrow.
module alu_mp_sequencer
  import alu_mp_sequencer_pkg::*;
#(
  parameter int W  = 4,
  parameter int NW = 4
) (
  input  logic                clk,
  input  logic                reset,
  alu_mp_sequencer_if.slave   bus,
  output logic [2:0]          alu_ctrl,
  output logic [W-1:0]        alu_a,
  output logic [W-1:0]        alu_b,
  input  logic [W-1:0]        alu_y,
  input  logic                alu_co
);

  localparam int FW = NW * W;
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;

  state_t          state, state_nxt;
  logic [2:0]      op_q;
  logic [FW-1:0]   a_q, b_q, y_q, y_nxt;
  logic [IW-1:0]   idx;
  logic            c1, cin;
  logic            n_q, z_q, c_q, v_q;
  logic            last, arith, carry_out, v_nxt, y_msb;

  assign last      = (idx == IW'(NW - 1));
  assign arith     = is_arith(op_q);
  assign carry_out = c1 | alu_co;
  assign y_msb     = y_nxt[FW-1];

  assign bus.cmd_ready = (state == IDLE);
  assign bus.res_valid = (state == DONE);
  assign bus.res_y     = y_q;
  assign bus.res_n     = n_q;
  assign bus.res_z     = z_q;
  assign bus.res_c     = c_q;
  assign bus.res_v     = v_q;

  always_comb begin
    state_nxt = state;
    alu_ctrl  = 3'b000;
    alu_a     = '0;
    alu_b     = '0;
    y_nxt     = y_q;
    v_nxt     = 1'b0;
    case (state)
      IDLE: if (bus.cmd_valid) state_nxt = P1;
      P1: begin
        alu_ctrl = op_q;
        alu_a    = a_q[idx*W +: W];
        alu_b    = b_q[idx*W +: W];
        y_nxt[idx*W +: W] = alu_y;
        if (arith)     state_nxt = P2;
        else if (last) state_nxt = DONE;
      end
      P2: begin
        alu_ctrl = op_q;
        alu_a    = y_q[idx*W +: W];
        alu_b    = {{(W-1){1'b0}}, cin};
        y_nxt[idx*W +: W] = alu_y;
        if (last) state_nxt = DONE;
        else      state_nxt = P1;
      end
      DONE: if (bus.res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Overflow uses the post-swap operands, so B-A is covered by the SUB rule
    if (op_q == OP_ADD)
      v_nxt = (a_q[FW-1] == b_q[FW-1]) && (y_msb != a_q[FW-1]);
    else if (op_q == OP_SUB)
      v_nxt = (a_q[FW-1] != b_q[FW-1]) && (y_msb != a_q[FW-1]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      op_q  <= 3'b000;
      a_q   <= '0;
      b_q   <= '0;
      y_q   <= '0;
      idx   <= '0;
      c1    <= 1'b0;
      cin   <= 1'b0;
      n_q   <= 1'b0;
      z_q   <= 1'b0;
      c_q   <= 1'b0;
      v_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (bus.cmd_valid) begin
          op_q <= (bus.cmd_op == OP_BMA) ? OP_SUB : bus.cmd_op;
          a_q  <= (bus.cmd_op == OP_BMA) ? bus.cmd_b : bus.cmd_a;
          b_q  <= (bus.cmd_op == OP_BMA) ? bus.cmd_a : bus.cmd_b;
          y_q  <= '0;
          idx  <= '0;
          c1   <= 1'b0;
          cin  <= 1'b0;
        end
        P1: begin
          y_q <= y_nxt;
          c1  <= alu_co;
          if (!arith) begin
            if (last) begin
              n_q <= y_msb;
              z_q <= (y_nxt == '0);
              c_q <= 1'b0;
              v_q <= 1'b0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        P2: begin
          y_q <= y_nxt;
          cin <= carry_out;
          if (last) begin
            n_q <= y_msb;
            z_q <= (y_nxt == '0);
            c_q <= carry_out;
            v_q <= v_nxt;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mp_sequencer.sv
// Table-driven scoreboard bench for alu_mp_sequencer with a behavioural
// 4-bit ALU (CO is carry for add, borrow for the subtract ops).
module tb_alu_mp_sequencer;

  localparam int W  = 4;
  localparam int NW = 4;
  localparam int FW = W * NW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_mp_sequencer_if #(.W(W), .NW(NW)) bus();

  logic [2:0]   alu_ctrl;
  logic [W-1:0] alu_a, alu_b, alu_y;
  logic         alu_co;

  alu_mp_sequencer #(.W(W), .NW(NW)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_y(alu_y), .alu_co(alu_co)
  );

  always_comb begin
    alu_y  = '0;
    alu_co = 1'b0;
    case (alu_ctrl)
      3'b000: {alu_co, alu_y} = {1'b0, alu_a} + {1'b0, alu_b};
      3'b001: begin alu_y = alu_a - alu_b; alu_co = (alu_a < alu_b); end
      3'b010: begin alu_y = alu_b - alu_a; alu_co = (alu_b < alu_a); end
      3'b011: alu_y = alu_a & ~alu_b;
      3'b100: alu_y = alu_a & alu_b;
      3'b101: alu_y = alu_a | alu_b;
      3'b110: alu_y = alu_a ^ alu_b;
      default: alu_y = ~(alu_a ^ alu_b);
    endcase
  end

  typedef struct {
    logic [2:0]    op;
    logic [FW-1:0] a;
    logic [FW-1:0] b;
    logic [FW-1:0] y;
    logic          n, z, c, v;
  } vec_t;

  typedef struct {
    logic [FW-1:0] y;
    logic          n, z, c, v;
    int            lat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[14];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Issue one command, then wait (bounded) for the result and score it.
  task automatic send(input logic [2:0] op, input logic [FW-1:0] a, input logic [FW-1:0] b,
                      input logic [FW-1:0] ey, input logic en, input logic ez,
                      input logic ec, input logic ev, input string tag);
    exp_t e, got;
    int   waited;
    int   cyc;
    @(negedge clk);
    waited = 0;
    while (!bus.cmd_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check({tag, " cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    e.y = ey; e.n = en; e.z = ez; e.c = ec; e.v = ev;
    e.lat = (op <= 3'b010) ? 2 * NW : NW;
    sb.push_back(e);
    cyc = 0;
    while (!bus.res_valid && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, " res_valid"}, 32'(bus.res_valid), 32'd1);
    if (sb.size() != 0) begin
      got = sb.pop_front();
      if (bus.res_valid) begin
        check({tag, " latency"}, 32'(cyc), 32'(got.lat));
        check({tag, " res_y"}, 32'(bus.res_y), 32'(got.y));
        check({tag, " nzcv"}, 32'({bus.res_n, bus.res_z, bus.res_c, bus.res_v}),
              32'({got.n, got.z, got.c, got.v}));
      end
    end
  endtask

  task automatic release_res(input string tag);
    @(negedge clk);
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    check({tag, " idle cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    check({tag, " idle res_valid"}, 32'(bus.res_valid), 32'd0);
  endtask

  initial begin
    logic [FW-1:0] held_y;
    vecs[0]  = '{3'b000, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{3'b000, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{3'b000, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{3'b001, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{3'b001, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{3'b010, 16'h0003, 16'h0010, 16'h000D, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{3'b110, 16'hF0F0, 16'hFFFF, 16'h0F0F, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{3'b011, 16'hFFFF, 16'h00F0, 16'hFF0F, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{3'b100, 16'h1234, 16'h00FF, 16'h0034, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{3'b101, 16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{3'b111, 16'h0000, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{3'b000, 16'h8000, 16'h8000, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[12] = '{3'b010, 16'h0005, 16'h0003, 16'hFFFE, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{3'b001, 16'h1000, 16'h0001, 16'h0FFF, 1'b0, 1'b0, 1'b0, 1'b0};

    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'b000;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("reset res_valid", 32'(bus.res_valid), 32'd0);
    check("reset res_y", 32'(bus.res_y), 32'd0);
    check("reset nzcv", 32'({bus.res_n, bus.res_z, bus.res_c, bus.res_v}), 32'd0);
    check("reset alu bus", 32'({alu_ctrl, alu_a, alu_b}), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].y,
           vecs[i].n, vecs[i].z, vecs[i].c, vecs[i].v, $sformatf("vec%0d", i));
      release_res($sformatf("vec%0d", i));
    end

    // Result must hold and commands must be refused while the consumer stalls
    send(3'b000, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0, 1'b0, 1'b0, "hold");
    held_y = bus.res_y;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.cmd_valid = ~bus.cmd_valid;
      bus.cmd_op    = 3'(k);
      bus.cmd_a     = 16'($urandom);
      bus.cmd_b     = 16'($urandom);
      @(posedge clk);
      #1;
      check($sformatf("hold%0d res_y", k), 32'(bus.res_y), 32'(held_y));
      check($sformatf("hold%0d res_valid", k), 32'(bus.res_valid), 32'd1);
      check($sformatf("hold%0d cmd_ready", k), 32'(bus.cmd_ready), 32'd0);
      check($sformatf("hold%0d nzcv", k), 32'({bus.res_n, bus.res_z, bus.res_c, bus.res_v}), 32'd0);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    release_res("hold");
    @(posedge clk);
    #1;
    check("hold no accept", 32'(bus.cmd_ready), 32'd1);

    // Abort with reset during the correction pass of word 2
    @(negedge clk);
    bus.cmd_op    = 3'b001;
    bus.cmd_a     = 16'h0000;
    bus.cmd_b     = 16'h0001;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("abort P2 alu_ctrl", 32'(alu_ctrl), 32'd1);
    check("abort P2 alu_b cin", 32'(alu_b), 32'd1);
    check("abort P2 alu_a", 32'(alu_a), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("abort res_valid", 32'(bus.res_valid), 32'd0);
    check("abort res_y", 32'(bus.res_y), 32'd0);
    check("abort alu bus", 32'({alu_ctrl, alu_a, alu_b}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    send(3'b000, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0, 1'b0, 1'b0, "after_abort");
    release_res("after_abort");

    check("scoreboard empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
